lsu_seq: RTL and testbench

Load/store sequencer sitting directly upstream of the memory interface (`memInerf`) in the execute path. Accepts one load/store request at a time from the execute stage over a valid/ready handshake. Drives `memInerf`'s `store`/`load`/`result`/`addr` inputs and waits on `mem_done`. Splits 16-bit loads into two byte reads, because the memory interface returns 8 bits per load, and delivers assembled, extended load data to the register-file write-back port.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_watchdog.sv | 30 +++
 rtl/lsu_seq.sv | 158 +++++++++++++++
 tb/tb_lsu_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
package lsu_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;

    // Operation encoding as presented by the execute stage.
    typedef enum logic [1:0] {
        OP_LBU = 2'b00,
        OP_LB  = 2'b01,
        OP_LW  = 2'b10,
        OP_SW  = 2'b11
    } lsu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_LO = 3'd1,
        ST_GAP    = 3'd2,
        ST_REQ_HI = 3'd3,
        ST_DONE   = 3'd4
    } lsu_state_e;

    // Builds write-back data from the captured bytes: zero-extend for LBU,
    // sign-extend for LB, little-endian assembly for LW.
    function automatic logic [DATA_W-1:0] wb_format(input lsu_op_e op,
                                                    input logic [BYTE_W-1:0] lo,
                                                    input logic [BYTE_W-1:0] hi);
        logic [DATA_W-1:0] d;
        case (op)
            OP_LB:   d = {{BYTE_W{lo[BYTE_W-1]}}, lo};
            OP_LW:   d = {hi, lo};
            default: d = {{BYTE_W{1'b0}}, lo};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_watchdog.sv
// Strobe watchdog: counts cycles spent waiting on the memory interface and
// flags the terminal cycle so the sequencer can abort.
module lsu_watchdog
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] count;

    // Count is zero on the first strobe cycle and advances while the strobe waits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expire = enable && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/lsu_seq.sv
// Load/store sequencer in front of the byte-wide memory interface. Byte loads
// take one access, 16-bit loads take two byte accesses separated by an idle
// cycle, 16-bit stores take one access.
//
// Request handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only while idle, and the req_*
// fields are only looked at on that transfer edge.
module lsu_seq
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int RD_W    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              mem_store,
    output logic              mem_load,
    output logic [DATA_W-1:0] mem_result,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [BYTE_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              st_done,
    output logic              err_timeout,
    output logic              busy,
    output lsu_state_e        dbg_state
);

    lsu_state_e        state, state_n;
    lsu_op_e           op_q, op_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [RD_W-1:0]   rd_q, rd_n;
    logic [BYTE_W-1:0] lo_q, lo_n, hi_q, hi_n;
    logic              abort;
    logic              in_req;
    logic              expire;
    logic              accept;

    assign in_req    = (state == ST_REQ_LO) || (state == ST_REQ_HI);
    assign accept    = (state == ST_IDLE) && req_valid && req_ready;
    assign dbg_state = state;

    lsu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!in_req),
        .enable  (in_req),
        .expire  (expire)
    );

    // Next state and next latched request/byte values; mem_done beats expire.
    always_comb begin
        state_n = state;
        op_n    = op_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        rd_n    = rd_q;
        lo_n    = lo_q;
        hi_n    = hi_q;
        abort   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_REQ_LO;
                    op_n    = lsu_op_e'(req_op);
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    rd_n    = req_rd;
                    lo_n    = '0;
                    hi_n    = '0;
                end
            end
            ST_REQ_LO: begin
                if (mem_done) begin
                    if (op_q != OP_SW) lo_n = mem_rdata;
                    state_n = (op_q == OP_LW) ? ST_GAP : ST_DONE;
                end else if (expire) begin
                    state_n = ST_IDLE;
                    abort   = 1'b1;
                end
            end
            ST_GAP: begin
                state_n = ST_REQ_HI;
            end
            ST_REQ_HI: begin
                if (mem_done) begin
                    hi_n    = mem_rdata;
                    state_n = ST_DONE;
                end else if (expire) begin
                    state_n = ST_IDLE;
                    abort   = 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, latched request and all outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            op_q        <= OP_LBU;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            mem_load    <= 1'b0;
            mem_store   <= 1'b0;
            mem_addr    <= '0;
            mem_result  <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            st_done     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            op_q        <= op_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            rd_q        <= rd_n;
            lo_q        <= lo_n;
            hi_q        <= hi_n;
            req_ready   <= (state_n == ST_IDLE);
            busy        <= (state_n != ST_IDLE);
            mem_load    <= ((state_n == ST_REQ_LO) && (op_n != OP_SW)) ||
                           (state_n == ST_REQ_HI);
            mem_store   <= (state_n == ST_REQ_LO) && (op_n == OP_SW);
            mem_addr    <= (state_n == ST_REQ_LO) ? addr_n :
                           (state_n == ST_REQ_HI) ? addr_n + ADDR_W'(1) : '0;
            mem_result  <= ((state_n == ST_REQ_LO) && (op_n == OP_SW)) ? wdata_n : '0;
            wb_valid    <= (state_n == ST_DONE) && (op_n != OP_SW);
            wb_rd       <= ((state_n == ST_DONE) && (op_n != OP_SW)) ? rd_n : '0;
            wb_data     <= ((state_n == ST_DONE) && (op_n != OP_SW)) ?
                           wb_format(op_n, lo_n, hi_n) : '0;
            st_done     <= (state_n == ST_DONE) && (op_n == OP_SW);
            err_timeout <= abort;
        end
    end

endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq with a byte-wide memory model and a write-back
// scoreboard.
module tb_lsu_seq;
    import lsu_pkg::*;

    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = 2'b00;
    logic [13:0]       req_addr = '0;
    logic [15:0]       req_wdata = '0;
    logic [3:0]        req_rd = '0;
    logic              mem_store, mem_load;
    logic [15:0]       mem_result;
    logic [13:0]       mem_addr;
    logic              mem_done = 1'b0;
    logic [7:0]        mem_rdata = '0;
    logic              wb_valid;
    logic [3:0]        wb_rd;
    logic [15:0]       wb_data;
    logic              st_done, err_timeout, busy;
    lsu_state_e        dbg_state;

    logic [7:0]  mem_model [0:16383];
    logic [19:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;
    int wb_cnt   = 0;
    int st_cnt   = 0;
    int to_cnt   = 0;

    lsu_seq #(.TIMEOUT(TO), .RD_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .mem_store   (mem_store),
        .mem_load    (mem_load),
        .mem_result  (mem_result),
        .mem_addr    (mem_addr),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .st_done     (st_done),
        .err_timeout (err_timeout),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (wb_valid) begin
            wb_cnt++;
            if (exp_q.size() == 0) check("wb_unexpected", {wb_rd, wb_data}, 20'h0);
            else check("wb_rd_data", {wb_rd, wb_data}, exp_q.pop_front());
        end
        if (st_done) st_cnt++;
        if (err_timeout) to_cnt++;
    end

    task automatic wait_ready(input string tag);
        int i;
        for (i = 0; i < 20; i++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        if (i == 20) check({tag, "_ready_wait"}, 0, 1);
    endtask

    // Holds one strobe phase, answering mem_done on strobe cycle 'lat' (0 = never).
    task automatic strobe_phase(input int lat, output int cnt, output logic [13:0] a,
                                output logic st, output logic [15:0] res);
        logic [13:0] ap;
        cnt = 0; a = '0; st = 1'b0; res = '0;
        for (int i = 0; i < 40; i++) begin
            if (!(mem_load || mem_store)) break;
            if (mem_load && mem_store) check("both_strobes", 1, 0);
            if (cnt == 0) begin a = mem_addr; st = mem_store; res = mem_result; end
            cnt++;
            if (cnt == lat) begin
                mem_done = 1'b1;
                if (mem_load) mem_rdata = mem_model[mem_addr];
                if (mem_store) begin
                    ap = mem_addr + 14'd1;
                    mem_model[mem_addr] = mem_result[7:0];
                    mem_model[ap] = mem_result[15:8];
                end
            end
            @(negedge clk);
            mem_done = 1'b0;
            mem_rdata = 8'($urandom);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [13:0] addr,
                         input logic [15:0] wdata, input logic [3:0] rd,
                         input int lat_lo, input int lat_hi, input logic [13:0] exp_hi_addr,
                         input int exp_lo_cnt, input int exp_hi_cnt, input logic exp_to);
        int cnt;
        logic [13:0] a;
        logic st;
        logic [15:0] res;
        int wb0, sd0, to0;
        wait_ready(tag);
        wb0 = wb_cnt; sd0 = st_cnt; to0 = to_cnt;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 2'($urandom); req_addr = 14'($urandom);
        req_wdata = 16'($urandom); req_rd = 4'($urandom);
        strobe_phase(lat_lo, cnt, a, st, res);
        check({tag, "_lo_cnt"}, cnt, exp_lo_cnt);
        check({tag, "_lo_addr"}, a, addr);
        check({tag, "_is_store"}, st, op == 2'b11);
        check({tag, "_result"}, res, (op == 2'b11) ? wdata : 16'h0);
        if (op == 2'b10 && !exp_to) begin
            check({tag, "_gap"}, {mem_load, mem_store, busy}, 3'b001);
            @(negedge clk);
            strobe_phase(lat_hi, cnt, a, st, res);
            check({tag, "_hi_cnt"}, cnt, exp_hi_cnt);
            check({tag, "_hi_addr"}, a, exp_hi_addr);
        end
        if (exp_to) begin
            check({tag, "_to_cycle"}, {err_timeout, busy, req_ready}, 3'b101);
        end else begin
            check({tag, "_done_cycle"}, {busy, req_ready, st_done}, {2'b10, op == 2'b11});
        end
        @(negedge clk);
        check({tag, "_idle"}, {req_ready, busy, err_timeout, wb_valid, st_done}, 5'b10000);
        check({tag, "_wb_pulses"}, wb_cnt - wb0, (!exp_to && op != 2'b11) ? 1 : 0);
        check({tag, "_st_pulses"}, st_cnt - sd0, (!exp_to && op == 2'b11) ? 1 : 0);
        check({tag, "_to_pulses"}, to_cnt - to0, exp_to ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    // Directed sequence
    initial begin
        int cnt, wb0;
        logic [13:0] a;
        logic st;
        logic [15:0] res;

        mem_model[14'h0010] = 8'h9C;
        mem_model[14'h0020] = 8'h9C;
        mem_model[14'h3FFF] = 8'h34;
        mem_model[14'h0000] = 8'h12;
        mem_model[14'h0040] = 8'h77;
        mem_model[14'h0200] = 8'h11;
        mem_model[14'h0201] = 8'h22;
        mem_model[14'h0300] = 8'h80;
        mem_model[14'h0050] = 8'hA5;

        // Reset
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {req_ready, mem_store, mem_load, mem_result, mem_addr, wb_valid, wb_rd,
               wb_data, st_done, err_timeout, busy}, 57'h0);
        check("reset_state", dbg_state, ST_IDLE);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", {req_ready, busy}, 2'b10);

        exp_q.push_back({4'd3, 16'h009C});
        do_op("lbu", 2'b00, 14'h0010, 16'h0, 4'd3, 3, 0, 14'h0, 3, 0, 1'b0);

        exp_q.push_back({4'd5, 16'hFF9C});
        do_op("lb_neg", 2'b01, 14'h0020, 16'h0, 4'd5, 1, 0, 14'h0, 1, 0, 1'b0);

        mem_model[14'h0020] = 8'h5A;
        exp_q.push_back({4'd6, 16'h005A});
        do_op("lb_pos", 2'b01, 14'h0020, 16'h0, 4'd6, 2, 0, 14'h0, 2, 0, 1'b0);

        exp_q.push_back({4'd7, 16'h1234});
        do_op("lw_wrap", 2'b10, 14'h3FFF, 16'h0, 4'd7, 2, 1, 14'h0000, 2, 1, 1'b0);

        do_op("sw", 2'b11, 14'h0100, 16'hBEEF, 4'd1, 2, 0, 14'h0, 2, 0, 1'b0);

        exp_q.push_back({4'd9, 16'hBEEF});
        do_op("lw_back", 2'b10, 14'h0100, 16'h0, 4'd9, 1, 3, 14'h0101, 1, 3, 1'b0);

        do_op("timeout", 2'b00, 14'h0040, 16'h0, 4'd2, 0, 0, 14'h0, TO, 0, 1'b1);

        exp_q.push_back({4'd2, 16'h0077});
        do_op("done_last", 2'b00, 14'h0040, 16'h0, 4'd2, TO, 0, 14'h0, TO, 0, 1'b0);

        exp_q.push_back({4'd4, 16'h00A5});
        do_op("lbu_fast", 2'b00, 14'h0050, 16'h0, 4'd4, 1, 0, 14'h0, 1, 0, 1'b0);

        // Reset while an LW waits in its high-byte phase
        wait_ready("rst");
        wb0 = wb_cnt;
        req_valid = 1'b1; req_op = 2'b10; req_addr = 14'h0200; req_rd = 4'd8;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        strobe_phase(1, cnt, a, st, res);
        check("rst_lo_cnt", cnt, 1);
        @(negedge clk);
        check("rst_hi_strobe", {mem_load, mem_addr}, {1'b1, 14'h0201});
        @(negedge clk);
        check("rst_hi_state", dbg_state, ST_REQ_HI);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs",
              {req_ready, mem_store, mem_load, mem_result, mem_addr, wb_valid, wb_rd,
               wb_data, st_done, err_timeout, busy}, 57'h0);
        check("rst_mid_state", dbg_state, ST_IDLE);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_no_wb", wb_cnt - wb0, 0);

        exp_q.push_back({4'd15, 16'hFF80});
        do_op("after_rst", 2'b01, 14'h0300, 16'h0, 4'd15, 1, 0, 14'h0, 1, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
